// File: rtl/vec_pkg.sv
// Shared constants, opcode encodings and sequencer state encoding for the vector ALU sequencer.
package vec_pkg;

  localparam int VEC_OPD_W = 512;
  localparam int VEC_RES_W = 1024;
  localparam int LANE_W    = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WB_LO = 3'd3,
    WB_HI = 3'd4
  } vec_state_e;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/vec_alu_sequencer_if.sv
// Instruction, register-file, ALU and status bundle between the sequencer and its neighbours.
interface vec_alu_sequencer_if #(
  parameter int RF_AW = 3,
  parameter int LANES = 16
);
  localparam int OPD_W = LANES * 32;
  localparam int RES_W = LANES * 64;

  logic             instr_valid;
  logic             instr_ready;
  logic [1:0]       instr_op;
  logic [RF_AW-1:0] instr_rs1;
  logic [RF_AW-1:0] instr_rs2;
  logic [RF_AW-1:0] instr_rd;
  logic [RF_AW-1:0] rf_rd_addr1;
  logic [RF_AW-1:0] rf_rd_addr2;
  logic [OPD_W-1:0] rf_rd_data1;
  logic [OPD_W-1:0] rf_rd_data2;
  logic [OPD_W-1:0] alu_a1;
  logic [OPD_W-1:0] alu_a2;
  logic [1:0]       alu_op;
  logic [RES_W-1:0] alu_result;
  logic             rf_wr_en;
  logic [RF_AW-1:0] rf_wr_addr;
  logic [OPD_W-1:0] rf_wr_data;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
    input  rf_rd_data1, rf_rd_data2, alu_result,
    output instr_ready, rf_rd_addr1, rf_rd_addr2,
    output alu_a1, alu_a2, alu_op,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    output busy, done, err
  );

  modport master (
    output instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
    output rf_rd_data1, rf_rd_data2, alu_result,
    input  instr_ready, rf_rd_addr1, rf_rd_addr2,
    input  alu_a1, alu_a2, alu_op,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    input  busy, done, err
  );

endinterface

// File: rtl/vec_seq_fsm.sv
// Sequencer control: state register, next-state logic, handshake and strobe outputs.
module vec_seq_fsm
  import vec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_instr_valid,
  input  logic i_op_legal,
  output logic o_instr_ready,
  output logic o_busy,
  output logic o_done,
  output logic o_err,
  output logic o_rf_wr_en,
  output logic o_accept,
  output logic o_cap_opd,
  output logic o_cap_res,
  output logic o_wb_lo,
  output logic o_wb_hi
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_READ  = READ;
  localparam logic [2:0] S_EXEC  = EXEC;
  localparam logic [2:0] S_WB_LO = WB_LO;
  localparam logic [2:0] S_WB_HI = WB_HI;

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic       r_err;
  logic       w_accept;

  assign w_accept = i_instr_valid && (r_state == S_IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && i_op_legal) w_state_next = S_READ;
      S_READ:  w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_WB_LO;
      S_WB_LO: w_state_next = S_WB_HI;
      S_WB_HI: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_accept && !i_op_legal;
    end
  end

  assign o_instr_ready = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_accept      = w_accept;
  assign o_cap_opd     = (r_state == S_READ);
  assign o_cap_res     = (r_state == S_EXEC);
  assign o_wb_lo       = (r_state == S_WB_LO);
  assign o_wb_hi       = (r_state == S_WB_HI);
  assign o_rf_wr_en    = o_wb_lo || o_wb_hi;
  assign o_done        = o_wb_hi;
  assign o_err         = r_err;

endmodule

// File: rtl/vec_alu_sequencer.sv
// Single-issue vector ALU sequencer: read two operands, run the ALU, write the result back as two halves.
// Optional performance counters are built when VEC_SEQ_PERF_EN is defined.
module vec_alu_sequencer
  import vec_pkg::*;
#(
  parameter int RF_AW = 3,
  parameter int LANES = 16
) (
  input  logic             clk,
  input  logic             rst,
  vec_alu_sequencer_if.slave bus
`ifdef VEC_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_instr_cnt,
  output logic [31:0]      perf_busy_cyc
`endif
);

  localparam int OPD_W = LANES * LANE_W;
  localparam int RES_W = 2 * OPD_W;

  logic             w_op_legal;
  logic             w_accept;
  logic             w_cap_opd;
  logic             w_cap_res;
  logic             w_wb_lo;
  logic             w_wb_hi;
  logic [RF_AW-1:0] w_rd_hi;

  logic [1:0]       r_op;
  logic [RF_AW-1:0] r_rs1;
  logic [RF_AW-1:0] r_rs2;
  logic [RF_AW-1:0] r_rd;
  logic [OPD_W-1:0] r_opd1;
  logic [OPD_W-1:0] r_opd2;
  logic [1:0]       r_alu_op;
  logic [RES_W-1:0] r_result;

  assign w_op_legal = op_is_legal(bus.instr_op);

  vec_seq_fsm u_fsm (
    .clk           (clk),
    .rst           (rst),
    .i_instr_valid (bus.instr_valid),
    .i_op_legal    (w_op_legal),
    .o_instr_ready (bus.instr_ready),
    .o_busy        (bus.busy),
    .o_done        (bus.done),
    .o_err         (bus.err),
    .o_rf_wr_en    (bus.rf_wr_en),
    .o_accept      (w_accept),
    .o_cap_opd     (w_cap_opd),
    .o_cap_res     (w_cap_res),
    .o_wb_lo       (w_wb_lo),
    .o_wb_hi       (w_wb_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_opd1   <= '0;
      r_opd2   <= '0;
      r_alu_op <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= bus.instr_op;
        r_rs1 <= bus.instr_rs1;
        r_rs2 <= bus.instr_rs2;
        r_rd  <= bus.instr_rd;
      end
      // ALU op is taken with the operands so it only ever shows a legal, executed opcode.
      if (w_cap_opd) begin
        r_opd1   <= bus.rf_rd_data1;
        r_opd2   <= bus.rf_rd_data2;
        r_alu_op <= r_op;
      end
      if (w_cap_res) begin
        r_result <= bus.alu_result;
      end
    end
  end

  // The RF registers its read address on the acceptance edge, so the incoming source index is
  // forwarded for a legal accept; data then lands during READ. Otherwise the latched index holds.
  assign bus.rf_rd_addr1 = (w_accept && w_op_legal) ? bus.instr_rs1 : r_rs1;
  assign bus.rf_rd_addr2 = (w_accept && w_op_legal) ? bus.instr_rs2 : r_rs2;

  assign bus.alu_a1 = r_opd1;
  assign bus.alu_a2 = r_opd2;
  assign bus.alu_op = r_alu_op;

  assign w_rd_hi = r_rd + 1'b1;

  assign bus.rf_wr_addr = w_wb_lo ? r_rd :
                          w_wb_hi ? w_rd_hi : '0;
  assign bus.rf_wr_data = w_wb_lo ? r_result[OPD_W-1:0] :
                          w_wb_hi ? r_result[RES_W-1:OPD_W] : '0;

`ifdef VEC_SEQ_PERF_EN
  logic [31:0] r_perf_instr_cnt;
  logic [31:0] r_perf_busy_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_instr_cnt <= '0;
      r_perf_busy_cyc  <= '0;
    end else begin
      if (bus.done) r_perf_instr_cnt <= r_perf_instr_cnt + 32'd1;
      if (bus.busy) r_perf_busy_cyc  <= r_perf_busy_cyc + 32'd1;
    end
  end

  assign perf_instr_cnt = r_perf_instr_cnt;
  assign perf_busy_cyc  = r_perf_busy_cyc;
`endif

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer with a registered-read RF model and a lane-wise ALU model.
module tb_vec_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vec_alu_sequencer_if #(.RF_AW(3), .LANES(16)) bus_if ();

`ifdef VEC_SEQ_PERF_EN
  logic [31:0] perf_instr_cnt;
  logic [31:0] perf_busy_cyc;
`endif

  vec_alu_sequencer #(.RF_AW(3), .LANES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef VEC_SEQ_PERF_EN
    ,
    .perf_instr_cnt (perf_instr_cnt),
    .perf_busy_cyc  (perf_busy_cyc)
`endif
  );

  logic [511:0] mem [8];

  always @(posedge clk) begin
    bus_if.rf_rd_data1 <= mem[bus_if.rf_rd_addr1];
    bus_if.rf_rd_data2 <= mem[bus_if.rf_rd_addr2];
    if (bus_if.rf_wr_en) mem[bus_if.rf_wr_addr] <= bus_if.rf_wr_data;
  end

  function automatic logic [1023:0] alu_f(input logic [511:0] a, input logic [511:0] b,
                                          input logic [1:0] op);
    logic [1023:0] r;
    logic [63:0]   x, y;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      x = {{32{a[i*32+31]}}, a[i*32 +: 32]};
      y = {{32{b[i*32+31]}}, b[i*32 +: 32]};
      r[i*64 +: 64] = (op == 2'b01) ? x * y : x + y;
    end
    return r;
  endfunction

  assign bus_if.alu_result = alu_f(bus_if.alu_a1, bus_if.alu_a2, bus_if.alu_op);

  function automatic logic [511:0] lanes32(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [511:0] lanes64(input logic [63:0] v);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd);
    bus_if.instr_valid = 1'b1;
    bus_if.instr_op    = op;
    bus_if.instr_rs1   = rs1;
    bus_if.instr_rs2   = rs2;
    bus_if.instr_rd    = rd;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus_if.busy && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy=%b required=0", name, bus_if.busy);
    end
  endtask

  task automatic test_reset();
    bus_if.instr_valid = 1'b0;
    bus_if.instr_op    = 2'b00;
    bus_if.instr_rs1   = 3'd0;
    bus_if.instr_rs2   = 3'd0;
    bus_if.instr_rd    = 3'd0;
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus_if.instr_ready, bus_if.busy, bus_if.done, bus_if.err, bus_if.rf_wr_en} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_strobes got=%b required=10000",
               {bus_if.instr_ready, bus_if.busy, bus_if.done, bus_if.err, bus_if.rf_wr_en});
    end
    checks++;
    if ({bus_if.alu_a1, bus_if.alu_a2, bus_if.rf_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_data a1=%h wr_data=%h required=0", bus_if.alu_a1, bus_if.rf_wr_data);
    end
    checks++;
    if ({bus_if.alu_op, bus_if.rf_rd_addr1, bus_if.rf_rd_addr2, bus_if.rf_wr_addr} !== 11'd0) begin
      errors++;
      $display("FAIL reset_addr got=%b required=0",
               {bus_if.alu_op, bus_if.rf_rd_addr1, bus_if.rf_rd_addr2, bus_if.rf_wr_addr});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus_if.instr_ready, bus_if.busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release got=%b required=10", {bus_if.instr_ready, bus_if.busy});
    end
  endtask

  task automatic test_add();
    mem[1] = lanes32(32'd5);
    mem[2] = lanes32(32'hFFFF_FFFD);
    drive(2'b00, 3'd1, 3'd2, 3'd4);
    tick();
    bus_if.instr_valid = 1'b0;
    checks++;
    if ({bus_if.instr_ready, bus_if.busy, bus_if.rf_wr_en} !== 3'b010) begin
      errors++;
      $display("FAIL add_read got=%b required=010", {bus_if.instr_ready, bus_if.busy, bus_if.rf_wr_en});
    end
    tick();
    checks++;
    if (bus_if.alu_a1 !== lanes32(32'd5) || bus_if.alu_a2 !== lanes32(32'hFFFF_FFFD) ||
        bus_if.alu_op !== 2'b00) begin
      errors++;
      $display("FAIL add_exec a1=%h a2=%h op=%b", bus_if.alu_a1, bus_if.alu_a2, bus_if.alu_op);
    end
    tick();
    checks++;
    if ({bus_if.rf_wr_en, bus_if.done} !== 2'b10 || bus_if.rf_wr_addr !== 3'd4 ||
        bus_if.rf_wr_data !== lanes64(64'd2)) begin
      errors++;
      $display("FAIL add_wb_lo en_done=%b addr=%0d data=%h required en_done=10 addr=4",
               {bus_if.rf_wr_en, bus_if.done}, bus_if.rf_wr_addr, bus_if.rf_wr_data);
    end
    tick();
    checks++;
    if ({bus_if.rf_wr_en, bus_if.done} !== 2'b11 || bus_if.rf_wr_addr !== 3'd5 ||
        bus_if.rf_wr_data !== lanes64(64'd2)) begin
      errors++;
      $display("FAIL add_wb_hi en_done=%b addr=%0d data=%h required en_done=11 addr=5",
               {bus_if.rf_wr_en, bus_if.done}, bus_if.rf_wr_addr, bus_if.rf_wr_data);
    end
    tick();
    checks++;
    if ({bus_if.instr_ready, bus_if.busy, bus_if.done, bus_if.rf_wr_en} !== 4'b1000) begin
      errors++;
      $display("FAIL add_idle got=%b required=1000",
               {bus_if.instr_ready, bus_if.busy, bus_if.done, bus_if.rf_wr_en});
    end
    checks++;
    if (mem[4] !== lanes64(64'd2) || mem[5] !== lanes64(64'd2)) begin
      errors++;
      $display("FAIL add_mem reg4=%h reg5=%h required lanes of 2", mem[4], mem[5]);
    end
  endtask

  task automatic test_mul_wrap();
    mem[3] = lanes32(32'h7FFF_FFFF);
    drive(2'b01, 3'd3, 3'd3, 3'd7);
    tick();
    bus_if.instr_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus_if.rf_wr_en !== 1'b1 || bus_if.rf_wr_addr !== 3'd7 ||
        bus_if.rf_wr_data !== lanes64(64'h3FFF_FFFF_0000_0001)) begin
      errors++;
      $display("FAIL mul_wb_lo en=%b addr=%0d data=%h required addr=7",
               bus_if.rf_wr_en, bus_if.rf_wr_addr, bus_if.rf_wr_data);
    end
    tick();
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.rf_wr_addr !== 3'd0 ||
        bus_if.rf_wr_data !== lanes64(64'h3FFF_FFFF_0000_0001)) begin
      errors++;
      $display("FAIL mul_wb_hi done=%b addr=%0d data=%h required addr=0",
               bus_if.done, bus_if.rf_wr_addr, bus_if.rf_wr_data);
    end
    tick();
    checks++;
    if (mem[7] !== lanes64(64'h3FFF_FFFF_0000_0001) || mem[0] !== lanes64(64'h3FFF_FFFF_0000_0001)) begin
      errors++;
      $display("FAIL mul_mem reg7=%h reg0=%h", mem[7], mem[0]);
    end
  endtask

  task automatic test_illegal();
    drive(2'b10, 3'd1, 3'd2, 3'd4);
    #1;
    checks++;
    if (bus_if.rf_rd_addr1 !== 3'd3) begin
      errors++;
      $display("FAIL illegal_no_read addr1=%0d required=3", bus_if.rf_rd_addr1);
    end
    tick();
    bus_if.instr_valid = 1'b0;
    checks++;
    if ({bus_if.err, bus_if.instr_ready, bus_if.busy, bus_if.rf_wr_en} !== 4'b1100) begin
      errors++;
      $display("FAIL illegal_err got=%b required=1100",
               {bus_if.err, bus_if.instr_ready, bus_if.busy, bus_if.rf_wr_en});
    end
    checks++;
    if (bus_if.alu_op !== 2'b01) begin
      errors++;
      $display("FAIL illegal_alu_op_hold got=%b required=01", bus_if.alu_op);
    end
    tick();
    checks++;
    if ({bus_if.err, bus_if.instr_ready, bus_if.rf_wr_en} !== 3'b010) begin
      errors++;
      $display("FAIL illegal_pulse got=%b required=010", {bus_if.err, bus_if.instr_ready, bus_if.rf_wr_en});
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic exp;
    drive(2'b00, 3'd1, 3'd2, 3'd6);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      acc = bus_if.instr_valid && bus_if.instr_ready;
      exp = (k % 5 == 0);
      checks++;
      if (acc !== exp) begin
        errors++;
        $display("FAIL b2b_accept cycle=%0d got=%b required=%b", k, acc, exp);
      end
    end
    bus_if.instr_valid = 1'b0;
    tick();
    wait_idle("b2b");
    checks++;
    if (mem[6] !== lanes64(64'd2) || mem[7] !== lanes64(64'd2)) begin
      errors++;
      $display("FAIL b2b_mem reg6=%h reg7=%h required lanes of 2", mem[6], mem[7]);
    end
  endtask

  task automatic test_reset_mid_wb();
    drive(2'b00, 3'd1, 3'd1, 3'd5);
    tick();
    bus_if.instr_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus_if.rf_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rstwb_reach en=%b required=1", bus_if.rf_wr_en);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.rf_wr_en, bus_if.instr_ready, bus_if.busy} !== 3'b010 || bus_if.rf_wr_data !== '0 ||
        bus_if.alu_a1 !== '0) begin
      errors++;
      $display("FAIL rstwb_async en_rdy_busy=%b required=010 wr_data=%h",
               {bus_if.rf_wr_en, bus_if.instr_ready, bus_if.busy}, bus_if.rf_wr_data);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus_if.rf_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL rstwb_no_write cycle=%0d en=%b required=0", k, bus_if.rf_wr_en);
      end
    end
    checks++;
    if (mem[5] !== lanes64(64'd2) || mem[6] !== lanes64(64'd2)) begin
      errors++;
      $display("FAIL rstwb_mem reg5=%h reg6=%h required lanes of 2", mem[5], mem[6]);
    end
  endtask

`ifdef VEC_SEQ_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (perf_instr_cnt !== 32'd0 || perf_busy_cyc !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset instr=%0d busy=%0d required=0", perf_instr_cnt, perf_busy_cyc);
    end
    for (int k = 0; k < 4; k++) begin
      drive((k == 2) ? 2'b11 : 2'b00, 3'd1, 3'd2, 3'd4);
      tick();
      bus_if.instr_valid = 1'b0;
      wait_idle("perf");
    end
    tick();
    checks++;
    if (perf_instr_cnt !== 32'd3 || perf_busy_cyc !== 32'd12) begin
      errors++;
      $display("FAIL perf_count instr=%0d busy=%0d required instr=3 busy=12",
               perf_instr_cnt, perf_busy_cyc);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset();
    test_add();
    test_mul_wrap();
    test_illegal();
    test_back_to_back();
    test_reset_mid_wb();
`ifdef VEC_SEQ_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
